// File: rtl/add8u_err_monitor.sv
// add8u_err_monitor: streaming error-metric collector for an approximate unsigned adder.
// Each accepted (a, b, o) sample is compared with the exact a+b. The block accumulates
// the sum of |error|, the worst-case error, the erroneous-sample count and the sample count.
// Build option: define ADD8U_ERR_MSE_EN to add sum_sq_err, the saturating sum of d*d.
module add8u_err_monitor #(
  parameter int W     = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W:0]       in_o,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [W:0]       max_err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] samples
`ifdef ADD8U_ERR_MSE_EN
  ,
  output logic [2*(W+1)+CNT_W-1:0] sum_sq_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Unsigned distance between two (W+1)-bit values.
  function automatic logic [W:0] abs_diff(input logic [W:0] x, input logic [W:0] y);
    logic [W:0] r;
    if (x >= y) begin
      r = x - y;
    end else begin
      r = y - x;
    end
    return r;
  endfunction

  state_t             state_r, state_nxt_s;
  logic               busy_r, done_r;
  logic [CNT_W-1:0]   accepted_r, accepted_nxt_s, n_r;
  logic               in_ready_s, fire_s, start_ok_s;
  logic [W:0]         exact_s;
  logic               v1_r;
  logic [W:0]         d1_r;
  logic [ACC_W-1:0]   sum_abs_err_r;
  logic [ACC_W:0]     sum_ext_s;
  logic [ACC_W-1:0]   sum_sat_s;
  logic [W:0]         max_err_r;
  logic [CNT_W-1:0]   err_count_r, samples_r;

  // Ready only while a run still owes samples; combinational so the last accept closes the gate at once.
  assign in_ready_s     = (state_r == ST_RUN) && (accepted_r < n_r);
  assign fire_s         = in_valid & in_ready_s;
  assign start_ok_s     = start & ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign accepted_nxt_s = accepted_r + {{(CNT_W-1){1'b0}}, fire_s};
  assign exact_s        = {1'b0, in_a} + {1'b0, in_b};
  assign sum_ext_s      = {1'b0, sum_abs_err_r} + {{(ACC_W-W){1'b0}}, d1_r};
  assign sum_sat_s      = sum_ext_s[ACC_W] ? {ACC_W{1'b1}} : sum_ext_s[ACC_W-1:0];

  assign in_ready    = in_ready_s;
  assign busy        = busy_r;
  assign done        = done_r;
  assign sum_abs_err = sum_abs_err_r;
  assign max_err     = max_err_r;
  assign err_count   = err_count_r;
  assign samples     = samples_r;

  // Next-state logic: RUN leaves on the edge that accepts the last sample, DRAIN waits for stage 1 to empty.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (accepted_nxt_s == n_r) state_nxt_s = ST_DRAIN;
        else                       state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (!v1_r) state_nxt_s = ST_DONE;
        else       state_nxt_s = ST_DRAIN;
      end
      ST_DONE: begin
        if (start) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register with busy/done registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Run length is latched at start; the acceptance counter restarts with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      accepted_r <= {CNT_W{1'b0}};
      n_r        <= {CNT_W{1'b0}};
    end else if (start_ok_s) begin
      accepted_r <= {CNT_W{1'b0}};
      n_r        <= n_samples;
    end else begin
      accepted_r <= accepted_nxt_s;
    end
  end

  // Stage 1: absolute error of the accepted sample against the exact sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r <= 1'b0;
      d1_r <= {(W+1){1'b0}};
    end else begin
      v1_r <= fire_s;
      if (fire_s) begin
        d1_r <= abs_diff(in_o, exact_s);
      end
    end
  end

  // Stage 2: fold the stage-1 error into the run statistics; start clears them.
  always_ff @(posedge clk) begin
    if (rst || start_ok_s) begin
      sum_abs_err_r <= {ACC_W{1'b0}};
      max_err_r     <= {(W+1){1'b0}};
      err_count_r   <= {CNT_W{1'b0}};
      samples_r     <= {CNT_W{1'b0}};
    end else if (v1_r) begin
      sum_abs_err_r <= sum_sat_s;
      if (d1_r > max_err_r) begin
        max_err_r <= d1_r;
      end
      if (d1_r != {(W+1){1'b0}}) begin
        err_count_r <= err_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      samples_r <= samples_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef ADD8U_ERR_MSE_EN
  localparam int SQ_W = 2*(W+1)+CNT_W;

  logic [2*W+1:0]  sq_s;
  logic [SQ_W:0]   sse_ext_s;
  logic [SQ_W-1:0] sum_sq_err_r;

  assign sq_s       = d1_r * d1_r;
  assign sse_ext_s  = {1'b0, sum_sq_err_r} + {{(CNT_W+1){1'b0}}, sq_s};
  assign sum_sq_err = sum_sq_err_r;

  // Stage 2 squared-error accumulator, saturating like the |error| sum.
  always_ff @(posedge clk) begin
    if (rst || start_ok_s) begin
      sum_sq_err_r <= {SQ_W{1'b0}};
    end else if (v1_r) begin
      sum_sq_err_r <= sse_ext_s[SQ_W] ? {SQ_W{1'b1}} : sse_ext_s[SQ_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_add8u_err_monitor.sv
// Scoreboard bench for add8u_err_monitor: the driver pushes expected running stats per
// accepted sample and expected final stats per run; a monitor pops and compares.
module tb_add8u_err_monitor;
  localparam int W     = 8;
  localparam int CNT_W = 16;
  localparam int ACC_W = 25;
  localparam int SQ_W  = 2*(W+1)+CNT_W;
  localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;
  localparam longint SQ_MAX  = (longint'(1) << SQ_W) - 1;

  typedef struct {
    longint sum;
    longint mx;
    longint errs;
    longint smp;
    longint sse;
  } stats_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] n_samples = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic [W:0]       in_o = '0;
  logic             busy, done;
  logic [ACC_W-1:0] sum_abs_err;
  logic [W:0]       max_err;
  logic [CNT_W-1:0] err_count, samples;
`ifdef ADD8U_ERR_MSE_EN
  logic [SQ_W-1:0]  sum_sq_err;
`endif

  add8u_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .busy(busy), .done(done), .sum_abs_err(sum_abs_err), .max_err(max_err),
    .err_count(err_count), .samples(samples)
`ifdef ADD8U_ERR_MSE_EN
    , .sum_sq_err(sum_sq_err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  stats_t m;
  stats_t upd_q[$];
  stats_t run_q[$];

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: statistics follow from |o - (a+b)| with plain integer arithmetic.
  function automatic stats_t model_step(stats_t s, int a, int b, int o);
    stats_t r = s;
    longint d = (o > a + b) ? longint'(o - (a + b)) : longint'((a + b) - o);
    r.sum  = (s.sum + d > ACC_MAX) ? ACC_MAX : s.sum + d;
    r.mx   = (d > s.mx) ? d : s.mx;
    r.errs = s.errs + ((d != 0) ? 1 : 0);
    r.smp  = s.smp + 1;
    r.sse  = (s.sse + d*d > SQ_MAX) ? SQ_MAX : s.sse + d*d;
    return r;
  endfunction

  // Monitor: each change of the sample count is one stats update; a done rise ends a run.
  initial begin
    longint prev_smp = 0;
    logic   prev_done = 1'b0;
    stats_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (longint'(samples) != prev_smp && samples != '0) begin
          if (upd_q.size() == 0) begin
            check("unexpected_update", longint'(samples), prev_smp);
          end else begin
            e = upd_q.pop_front();
            check("upd_sum", longint'(sum_abs_err), e.sum);
            check("upd_max", longint'(max_err), e.mx);
            check("upd_errs", longint'(err_count), e.errs);
            check("upd_samples", longint'(samples), e.smp);
`ifdef ADD8U_ERR_MSE_EN
            check("upd_sse", longint'(sum_sq_err), e.sse);
`endif
          end
        end
        if (done && !prev_done) begin
          if (run_q.size() == 0) begin
            check("unexpected_done", longint'(done), 0);
          end else begin
            e = run_q.pop_front();
            check("fin_sum", longint'(sum_abs_err), e.sum);
            check("fin_max", longint'(max_err), e.mx);
            check("fin_errs", longint'(err_count), e.errs);
            check("fin_samples", longint'(samples), e.smp);
`ifdef ADD8U_ERR_MSE_EN
            check("fin_sse", longint'(sum_sq_err), e.sse);
`endif
          end
        end
      end
      prev_smp  = longint'(samples);
      prev_done = done;
    end
  end

  // All driver tasks start and end on a falling edge.
  task automatic start_run(input int n);
    start     = 1'b1;
    n_samples = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    m = '{default: 0};
  endtask

  task automatic send(input int a, input int b, input int o);
    int waited = 0;
    in_valid = 1'b1;
    in_a = W'(a);
    in_b = W'(b);
    in_o = (W+1)'(o);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready) begin
      m = model_step(m, a, b, o);
      upd_q.push_back(m);
    end else begin
      check("accept_timeout", longint'(in_ready), 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    check("done_reached", longint'(done), 1);
  endtask

  task automatic end_run();
    run_q.push_back(m);
    wait_done(20);
  endtask

  task automatic check_clear(input string nm);
    check({nm, "_ready"}, longint'(in_ready), 0);
    check({nm, "_busy"}, longint'(busy), 0);
    check({nm, "_done"}, longint'(done), 0);
    check({nm, "_stats"}, longint'(sum_abs_err) + longint'(max_err) +
          longint'(err_count) + longint'(samples), 0);
  endtask

  initial begin
    int last_acc, first_done, acc_cnt, a, b, o;
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int last_acc, first_done, acc_cnt, a, b, o;
    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_clear("reset");

    // Exact adder
    start_run(4);
    send(3, 4, 7); send(255, 255, 510); send(0, 0, 0); send(128, 1, 129);
    end_run();
    check("exact_sum", longint'(sum_abs_err), 0);
    check("exact_samples", longint'(samples), 4);

    // Erroneous adder, started from DONE
    start_run(3);
    send(3, 4, 5); send(10, 10, 31); send(0, 0, 0);
    end_run();
    check("err_sum", longint'(sum_abs_err), 13);
    check("err_max", longint'(max_err), 11);
    check("err_count", longint'(err_count), 2);
    check("err_samples", longint'(samples), 3);
`ifdef ADD8U_ERR_MSE_EN
    check("err_sse", longint'(sum_sq_err), 125);
`endif

    // Backpressure: valid held for 5 cycles against a 2-sample run
    start_run(2);
    acc_cnt = 0; last_acc = -10; first_done = -1;
    for (int i = 0; i < 5; i++) begin
      a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255));
      o = int'($urandom_range(0, 511));
      in_valid = 1'b1; in_a = W'(a); in_b = W'(b); in_o = (W+1)'(o);
      if (done && first_done < 0) first_done = i;
      if (in_ready) begin
        acc_cnt++; last_acc = i;
        m = model_step(m, a, b, o);
        upd_q.push_back(m);
        if (acc_cnt == 2) run_q.push_back(m);
      end else if (acc_cnt == 2) begin
        check("bp_ready_low", longint'(in_ready), 0);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_accepted", acc_cnt, 2);
    check("bp_done_delay", first_done - last_acc, 3);

    // Zero-length run: done without any acceptance while valid is offered
    start_run(0);
    run_q.push_back(m);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("zero_ready", longint'(in_ready), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_done(10);
    check("zero_samples", longint'(samples), 0);

    // start pulsed while busy is ignored
    start_run(3);
    send(20, 30, 40);
    start = 1'b1; n_samples = CNT_W'(7);
    @(negedge clk);
    start = 1'b0;
    check("busy_start_busy", longint'(busy), 1);
    send(1, 2, 300); send(200, 100, 44);
    end_run();
    check("busy_start_samples", longint'(samples), 3);

    // Saturation of the |error| sum
    start_run(3);
    send(0, 0, 0);
    repeat (3) @(negedge clk);
    force dut.sum_abs_err_r = ACC_W'(ACC_MAX - 5);
    #1;
    release dut.sum_abs_err_r;
    m.sum = ACC_MAX - 5;
    check("sat_preload", longint'(sum_abs_err), ACC_MAX - 5);
    @(negedge clk);
    send(0, 0, 511); send(255, 255, 1);
    end_run();
    check("sat_sum", longint'(sum_abs_err), ACC_MAX);

    // Reset mid-run
    start_run(4);
    send(5, 6, 7);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    upd_q.delete();
    check_clear("midrst");
    start_run(4);
    for (int i = 0; i < 4; i++) send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                                     int'($urandom_range(0, 511)));
    end_run();
    check("midrst_samples", longint'(samples), 4);

    // Random run with gaps and near-exact approximations
    start_run(20);
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255));
      o = a + b;
      if ($urandom_range(0, 1) == 1) o = o + int'($urandom_range(0, 40)) - 20;
      if (o < 0) o = 0;
      if (o > 511) o = 511;
      send(a, b, o);
    end
    end_run();

    repeat (3) @(negedge clk);
    check("queues_empty", upd_q.size() + run_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
